alu_mac: RTL and testbench

- Datapath stage directly downstream of the B-bus multiplexer.
- Consumes the 32-bit B-bus word, with the accumulator (AC) as the A operand.
- Single-cycle ops: pass, add, sub, inc, clear. Multi-cycle ops: iterative multiply and multiply-accumulate, used for kernel × pixel convolution sums.
- Result register feeds back to AC; the control unit sequences it with a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_mac_shift_add_mul.sv | 40 ++++
 rtl/alu_mac.sv | 104 ++++++++++
 tb/tb_alu_mac.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and saturation limits for the AC-side ALU/MAC stage.
package alu_pkg;
  localparam logic [2:0] ALU_NOP   = 3'b000;
  localparam logic [2:0] ALU_PASSB = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_INC   = 3'b100;
  localparam logic [2:0] ALU_CLR   = 3'b101;
  localparam logic [2:0] ALU_MUL   = 3'b110;
  localparam logic [2:0] ALU_MAC   = 3'b111;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;
endpackage

// File: rtl/alu_mac_shift_add_mul.sv
// Iterative shift-add multiplier: load latches operands, each step retires one multiplier bit.
// product is the partial sum including the current step, so it is final when last is high.
module shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);
  logic [WIDTH-1:0] mcand, mplr, partial;
  logic [CNT_W-1:0] cnt;

  assign product = partial + (mplr[0] ? mcand : '0);
  assign last    = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplr    <= '0;
      partial <= '0;
      cnt     <= '0;
    end else if (load) begin
      mcand   <= a;
      mplr    <= b;
      partial <= '0;
      cnt     <= '0;
    end else if (step) begin
      partial <= product;
      mcand   <= mcand << 1;
      mplr    <= mplr >> 1;
      cnt     <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_mac.sv
// ALU/MAC stage: single-cycle ops on AC and B-bus, plus WIDTH-cycle MUL/MAC with start/busy/done.
// Define ALU_SAT_EN to saturate ADD/SUB/INC and the MAC final add on signed overflow.
module alu_mac
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             busy,
  output logic             done
);
`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Subtraction is a + ~b + 1, so one overflow test covers both directions.
  function automatic logic [WIDTH-1:0] add_w(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic sub);
    logic [WIDTH-1:0] bb, s;
    bb = sub ? ~b : b;
    s  = a + bb + {{(WIDTH-1){1'b0}}, sub};
`ifdef ALU_SAT_EN
    if (a[WIDTH-1] == bb[WIDTH-1] && s[WIDTH-1] != a[WIDTH-1])
      s = a[WIDTH-1] ? SAT_LO : SAT_HI;
`endif
    return s;
  endfunction

  state_t           state;
  logic             is_mac;
  logic             load, last;
  logic [WIDTH-1:0] product, sc_res, mul_res;

  assign load = (state == ST_IDLE) && start && (alu_op[2:1] == 2'b11);

  shift_add_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (state == ST_MUL),
    .a       (A_in),
    .b       (B_in),
    .product (product),
    .last    (last)
  );

  // result is frozen during MUL, so it still holds the MAC base captured at start.
  assign mul_res = is_mac ? add_w(result, product, 1'b0) : product;

  always_comb begin
    sc_res = result;
    case (alu_op)
      ALU_PASSB: sc_res = B_in;
      ALU_ADD:   sc_res = add_w(A_in, B_in, 1'b0);
      ALU_SUB:   sc_res = add_w(A_in, B_in, 1'b1);
      ALU_INC:   sc_res = add_w(A_in, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0);
      ALU_CLR:   sc_res = '0;
      default:   sc_res = result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      is_mac <= 1'b0;
      result <= '0;
      z_flag <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          if (alu_op[2:1] == 2'b11) begin
            is_mac <= (alu_op == ALU_MAC);
            busy   <= 1'b1;
            state  <= ST_MUL;
          end else begin
            result <= sc_res;
            z_flag <= (sc_res == '0);
            done   <= 1'b1;
          end
        end
        ST_MUL: if (last) begin
          result <= mul_res;
          z_flag <= (mul_res == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mac.sv
// Directed-vector bench for alu_mac: reset, single-cycle ops, MUL/MAC timing and overflow.
module tb_alu_mac;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0]  alu_op = 3'b000;
  logic [31:0] A_in = '0, B_in = '0;
  logic [31:0] result;
  logic        z_flag, busy, done;
  int          total = 0, passed = 0;

  alu_mac dut (.clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .A_in(A_in), .B_in(B_in),
               .result(result), .z_flag(z_flag), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Drive at negedge; returns 1 time unit after the accepting edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); start = 1'b1; alu_op = op; A_in = a; B_in = b;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; #12;
    total++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else passed++;
    total++; if (z_flag !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_flags got z=%b busy=%b done=%b exp 1 0 0", z_flag, busy, done); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid_mul;
    int n; int seen_done;
    issue(3'b110, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    total++; if (result !== 32'h0 || z_flag !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid_mul got r=%h z=%b busy=%b done=%b exp 0 1 0 0", result, z_flag, busy, done);
    else passed++;
    @(negedge clk); rst = 1'b0;
    seen_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1; end
    total++; if (seen_done != 0) $display("FAIL rst_no_done got done pulse exp none"); else passed++;
    issue(3'b110, 32'd7, 32'd9);
    n = 0;
    while (busy && n < 100) begin n++; @(posedge clk); #1; end
    total++; if (n != 32) $display("FAIL mul79_busy_cycles got=%0d exp=32", n); else passed++;
    total++; if (result !== 32'd63 || done !== 1'b1)
      $display("FAIL mul79_result got r=%0d done=%b exp 63 1", result, done); else passed++;
  endtask

  task automatic test_single_cycle;
    issue(3'b010, 32'h5, 32'hA);
    total++; if (result !== 32'hF || done !== 1'b1 || z_flag !== 1'b0)
      $display("FAIL add got r=%h done=%b z=%b exp 0000000f 1 0", result, done, z_flag); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL add_done_width got done=%b exp 0", done); else passed++;
    issue(3'b011, 32'h5, 32'h5);
    total++; if (result !== 32'h0 || z_flag !== 1'b1)
      $display("FAIL sub_zero got r=%h z=%b exp 0 1", result, z_flag); else passed++;
    issue(3'b100, 32'h41, 32'h0);
    total++; if (result !== 32'h42) $display("FAIL inc got=%h exp=00000042", result); else passed++;
    issue(3'b101, 32'h41, 32'h99);
    total++; if (result !== 32'h0 || z_flag !== 1'b1)
      $display("FAIL clr got r=%h z=%b exp 0 1", result, z_flag); else passed++;
  endtask

  task automatic test_mul_neg;
    int n; int both;
    issue(3'b110, 32'hFFFF_FFFF, 32'd3);
    n = 0; both = 0;
    while (busy && n < 100) begin
      if (done) both = 1;
      if (n == 5) begin start = 1'b1; alu_op = 3'b101; end
      if (n == 6) start = 1'b0;
      n++; @(posedge clk); #1;
    end
    total++; if (n != 32) $display("FAIL mulneg_busy_cycles got=%0d exp=32", n); else passed++;
    total++; if (result !== 32'hFFFF_FFFD || done !== 1'b1 || busy !== 1'b0 || both != 0)
      $display("FAIL mulneg_result got r=%h done=%b busy=%b overlap=%0d exp fffffffd 1 0 0",
               result, done, busy, both); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || result !== 32'hFFFF_FFFD)
      $display("FAIL mulneg_after got done=%b r=%h exp 0 fffffffd", done, result); else passed++;
  endtask

  task automatic test_mac_seq;
    int n;
    logic [31:0] av [3] = '{32'd2, 32'd4, 32'hFFFF_FFFF};
    logic [31:0] bv [3] = '{32'd3, 32'd5, 32'd6};
    logic [31:0] ev [3] = '{32'd6, 32'd26, 32'd20};
    issue(3'b101, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      issue(3'b111, av[i], bv[i]);
      n = 0;
      while (busy && n < 100) begin n++; @(posedge clk); #1; end
      total++; if (result !== ev[i] || done !== 1'b1 || n != 32)
        $display("FAIL mac_step%0d got r=%0d done=%b cyc=%0d exp %0d 1 32", i, result, done, n, ev[i]);
      else passed++;
    end
  endtask

  task automatic test_overflow;
    logic [31:0] e_add, e_sub;
`ifdef ALU_SAT_EN
    e_add = 32'h7FFF_FFFF; e_sub = 32'h8000_0000;
`else
    e_add = 32'h8000_0000; e_sub = 32'h7FFF_FFFF;
`endif
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    total++; if (result !== e_add) $display("FAIL add_ovf got=%h exp=%h", result, e_add); else passed++;
    issue(3'b011, 32'h8000_0000, 32'h1);
    total++; if (result !== e_sub) $display("FAIL sub_ovf got=%h exp=%h", result, e_sub); else passed++;
  endtask

  task automatic test_illegal;
    int n;
    issue(3'b001, 32'h0, 32'h1234);
    issue(3'b000, 32'hDEAD, 32'hBEEF);
    total++; if (result !== 32'h1234 || done !== 1'b1)
      $display("FAIL nop_hold got r=%h done=%b exp 00001234 1", result, done); else passed++;
    issue(3'b110, 32'h10, 32'h10);
    n = 0;
    while (busy && n < 100) begin
      alu_op = 3'(n); B_in = 32'(n * 7); A_in = 32'hFFFF;
      n++; @(posedge clk); #1;
    end
    total++; if (result !== 32'h100 || n != 32)
      $display("FAIL mul_toggle got r=%h cyc=%0d exp 00000100 32", result, n); else passed++;
    issue(3'b110, 32'h1234_5678, 32'h0);
    n = 0;
    while (busy && n < 100) begin n++; @(posedge clk); #1; end
    total++; if (result !== 32'h0 || z_flag !== 1'b1 || n != 32)
      $display("FAIL mul_zero got r=%h z=%b cyc=%0d exp 0 1 32", result, z_flag, n); else passed++;
  endtask

  initial begin
    test_reset;
    test_reset_mid_mul;
    test_single_cycle;
    test_mul_neg;
    test_mac_seq;
    test_overflow;
    test_illegal;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
